nco_phase_sine_gen: RTL and testbench
=====================================

# nco_phase_sine_gen

Numerically controlled oscillator datapath that sits directly downstream of the NCO AXI4-Lite register file. It takes the programmed phase increment, phase offset and enable, runs a modulo-2^PHASE_WIDTH phase accumulator and converts each phase to a signed sine sample through a quarter-wave ROM. Samples leave on an AXI4-Stream master port with full backpressure support.

## Interface
- PHASE_WIDTH, 32: accumulator, increment and offset width.
- LUT_ADDR_WIDTH, 10: quarter-wave ROM address width (2^LUT_ADDR_WIDTH entries). Must be ≤ PHASE_WIDTH-2.
- OUT_WIDTH, 16: signed sample width.

- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  reset. Asynchronous, active-high. One clock; reset is asynchronous and active-high.
- phase_inc  in  PHASE_WIDTH  per-sample phase step, unsigned.
- phase_offset  in  PHASE_WIDTH  phase offset added after the accumulator.
- enable  in  1  produces one sample per pipeline advance while high.
- acc_clr  in  1  synchronous clear of the accumulator.
- m_axis_tdata  out  OUT_WIDTH  two's-complement sine sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream ready.

## Operation
- The pipeline has 3 register stages behind the accumulator (S1, S2, S3). A single advance strobe controls all of them: ce = !m_axis_tvalid || m_axis_tready.
- **Accumulator (acc).**
  - On ce && enable: acc <= acc + phase_inc, modulo 2^PHASE_WIDTH, wrapping silently.
  - On acc_clr: acc <= 0. This takes priority and is independent of ce.
  - Inputs are sampled only on ce cycles.
- **S1 (on ce).**
  - p = acc + phase_offset, modulo 2^PHASE_WIDTH.
  - q = p[PW-1:PW-2].
  - idx = p[PW-3 -: LUT_ADDR_WIDTH], which truncates the lower bits.
  - v1 <= enable.
- **S2 (on ce).**
  - Registered ROM read.
  - addr = idx for q=0 and q=2; addr = ~idx for q=1 and q=3.
  - Negate flag = q[1].
  - v2 <= v1.
- **S3 (on ce).**
  - m_axis_tdata <= negate ? -rom : rom.
  - m_axis_tvalid <= v2.
- **ROM contents.** LUT[k] = round(A·sin(π/2·(k+0.5)/2^LUT_ADDR_WIDTH)), where A = 2^(OUT_WIDTH-1)-1.
  - The half-LSB offset gives exact quarter symmetry.
  - Negation never overflows, since |sample| ≤ A.
- **Sample order.** After reset or clear, sample n carries phase n·phase_inc + phase_offset. The first sample's phase is phase_offset.
- **acc_clr** does not flush in-flight samples. Samples already in S1–S3 are delivered unchanged.
- **enable low:** bubbles (v=0) enter the pipeline and acc holds. Samples already in flight drain normally.

## Timing
- **Reset values:**
  - acc = 0, v1 = v2 = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0.
  - S1/S2 data registers = 0.
- **Latency:** 3 cycles from the cycle enable is sampled with ce=1 to m_axis_tvalid=1, assuming no stall.
- **Throughput:** 1 sample per cycle while enable=1 and tready=1.
- **Handshake:**
  - A transfer occurs when tvalid && tready.
  - Once tvalid is high, tdata and tvalid hold stable until accepted.
  - tvalid never drops without a transfer, except on ARESET.
- **Stall:** tvalid=1 && tready=0 freezes all stages and acc. No sample is lost or duplicated.
- **Reset mid-operation:** ARESET takes effect immediately and asynchronously. tvalid goes to 0 without a handshake. After release, the sequence restarts from acc=0.
- **Simultaneous events:**
  - acc_clr together with ce && enable: acc <= 0, with no increment applied that cycle.
  - A phase_inc change takes effect on the first ce cycle after it.

## Test plan
- **Quarter-cycle step.** PW=32, L=10, OW=16, phase_inc=0x40000000, offset=0, enable=1, tready=1. Output repeats 0x0019, 0x7FFF, 0xFFE7, 0x8001. The first valid appears 3 cycles after enable is sampled.
- **Offset, zero increment.** phase_inc=0, phase_offset=0x40000000. Output is constant 0x7FFF. With offset=0x80000000 it is constant 0xFFE7.
- **Wrap-around.** phase_inc=0xFFFFFFFF, offset=0. Outputs are 0x0019, then 0xFFE7 (p=0xFFFFFFFF, q=3, addr=0), with the acc continuing down modulo 2^32. A checker model must match 1024 samples.
- **Backpressure.** Quarter-step stimulus with tready randomly low 50% of cycles. The accepted sequence is exactly 0x0019, 0x7FFF, 0xFFE7, 0x8001 repeating. tdata is stable during every stall.
- **Clear.** Pulse acc_clr for one cycle mid-stream. The 3 in-flight samples continue the old sequence; the next sample restarts at 0x0019. Also assert acc_clr together with enable and check no increment is applied.
- **Reset mid-stream.** Assert ARESET while tvalid=1 and tready=0. tvalid and tdata are 0 within the same cycle, asynchronously. After release, the first sample is 0x0019.

Source files
------------

// File: rtl/nco_phase_sine_gen.sv
// Numerically controlled oscillator datapath: a modulo-2^PHASE_WIDTH phase
// accumulator, a quarter-wave sine ROM and an AXI4-Stream master output.
// There are three register stages behind the accumulator. They all advance on
// one strobe, so any backpressure freezes the whole pipe as a unit.
module nco_phase_sine_gen #(
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 10,
    parameter int OUT_WIDTH      = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic [PHASE_WIDTH-1:0] phase_offset,
    input  logic                   enable,
    input  logic                   acc_clr,
    output logic [OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int  LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
    // Top phase bits that are kept: 2 quadrant bits plus the ROM index.
    localparam int  HI_W      = LUT_ADDR_WIDTH + 2;
    localparam real PI_R      = 3.14159265358979323846;
    localparam real AMPL      = (2.0 ** (OUT_WIDTH - 1)) - 1.0;

    // Round to nearest for a non-negative real value.
    function automatic int round_pos(input real x);
        return $rtoi(x + 0.5);
    endfunction

    // Quarter-wave entry. The half-LSB phase offset makes the table symmetric,
    // so mirrored quadrants can reuse it through the inverted address.
    function automatic logic signed [OUT_WIDTH-1:0] lut_entry(input int k);
        real ang;
        ang = (PI_R / 2.0) * (real'(k) + 0.5) / real'(LUT_DEPTH);
        return OUT_WIDTH'(round_pos(AMPL * $sin(ang)));
    endfunction

    // |v| <= AMPL, so the negation cannot overflow.
    function automatic logic signed [OUT_WIDTH-1:0] cond_negate(
        input logic signed [OUT_WIDTH-1:0] v,
        input logic                        neg
    );
        return neg ? -v : v;
    endfunction

    logic signed [OUT_WIDTH-1:0] w_lut [LUT_DEPTH];

    for (genvar gk = 0; gk < LUT_DEPTH; gk++) begin : g_lut
        localparam logic signed [OUT_WIDTH-1:0] C_VAL = lut_entry(gk);
        assign w_lut[gk] = C_VAL;
    end

    logic                          w_ce;
    logic [HI_W-1:0]               w_phase_hi_p0;
    logic [LUT_ADDR_WIDTH-1:0]     w_addr_p1;

    logic [PHASE_WIDTH-1:0]        r_acc;
    logic [1:0]                    r_q_p1;
    logic [LUT_ADDR_WIDTH-1:0]     r_idx_p1;
    logic                          r_vld_p1;
    logic signed [OUT_WIDTH-1:0]   r_rom_p2;
    logic                          r_neg_p2;
    logic                          r_vld_p2;
    logic signed [OUT_WIDTH-1:0]   r_data_p3;
    logic                          r_vld_p3;

    assign w_ce = !r_vld_p3 || m_axis_tready;

    // Phase = accumulator + offset. Only the quadrant and index bits are kept.
    assign w_phase_hi_p0 = HI_W'((r_acc + phase_offset) >> (PHASE_WIDTH - HI_W));

    // Odd quadrants read the table backwards.
    assign w_addr_p1 = r_q_p1[0] ? ~r_idx_p1 : r_idx_p1;

    // Accumulator: clear has priority and does not wait for ce.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_ce && enable) begin
            r_acc <= r_acc + phase_inc;
        end
    end

    // ---- stage 1: quadrant / index split ----
    // Capture the quadrant and ROM index of the current phase.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_q_p1   <= '0;
            r_idx_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else if (w_ce) begin
            r_q_p1   <= w_phase_hi_p0[HI_W-1 -: 2];
            r_idx_p1 <= w_phase_hi_p0[LUT_ADDR_WIDTH-1:0];
            r_vld_p1 <= enable;
        end
    end

    // ---- stage 2: registered ROM read ----
    // Read the quarter-wave table and carry the sign of the lower half-wave.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rom_p2 <= '0;
            r_neg_p2 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_ce) begin
            r_rom_p2 <= w_lut[w_addr_p1];
            r_neg_p2 <= r_q_p1[1];
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- stage 3: sign apply / stream output ----
    // Output register. It holds while stalled, so tdata stays stable.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_data_p3 <= '0;
            r_vld_p3  <= 1'b0;
        end else if (w_ce) begin
            r_data_p3 <= cond_negate(r_rom_p2, r_neg_p2);
            r_vld_p3  <= r_vld_p2;
        end
    end

    assign m_axis_tdata  = r_data_p3;
    assign m_axis_tvalid = r_vld_p3;

endmodule

// File: tb/tb_nco_phase_sine_gen.sv
// Scoreboard bench for nco_phase_sine_gen. Stimulus pushes the expected
// samples. A monitor pops one per accepted transfer and checks stall
// stability.
module tb_nco_phase_sine_gen;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] phase_inc;
    logic [31:0] phase_offset;
    logic        enable;
    logic        acc_clr;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    nco_phase_sine_gen #(
        .PHASE_WIDTH   (32),
        .LUT_ADDR_WIDTH(10),
        .OUT_WIDTH     (16)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .phase_inc    (phase_inc),
        .phase_offset (phase_offset),
        .enable       (enable),
        .acc_clr      (acc_clr),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int          total = 0;
    int          bad   = 0;
    int          popped = 0;
    logic [15:0] expq[$];
    logic [15:0] QT[4] = '{16'h0019, 16'h7FFF, 16'hFFE7, 16'h8001};

    // Reference sine: the 12 top phase bits select a half-LSB-centred angle.
    function automatic logic [15:0] model(input logic [31:0] ph);
        logic [11:0] m;
        real         s;
        int          r;
        m = ph[31:20];
        s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(m) + 0.5) / 4096.0);
        r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every handshake, plus stall stability.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic [15:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'b0, m_axis_tvalid}, 32'd1);
                    check("stall_data", {16'b0, m_axis_tdata}, {16'b0, prev_data});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_sample: got 0x%0h expected none", m_axis_tdata);
                    end else begin
                        e = expq.pop_front();
                        check($sformatf("sample%0d", popped), {16'b0, m_axis_tdata}, {16'b0, e});
                    end
                    popped++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
            end
        end
    end

    task automatic apply_reset();
        @(negedge ACLK);
        #2;
        ARESET = 1'b1;
        enable = 1'b0;
        acc_clr = 1'b0;
        expq.delete();
        popped = 0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    task automatic wait_accepted(input int k, input bit rand_ready);
        int cyc;
        cyc = 0;
        while (popped < k && cyc < 8000) begin
            @(posedge ACLK);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
            cyc++;
        end
        m_axis_tready = 1'b1;
        check("accepted_count", (popped >= k) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic push_quarter(input int n);
        for (int i = 0; i < n; i++) expq.push_back(QT[i % 4]);
    endtask

    initial begin
        int n;
        ARESET = 1'b1;
        enable = 1'b0;
        acc_clr = 1'b0;
        phase_inc = '0;
        phase_offset = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("reset_tdata", {16'b0, m_axis_tdata}, 32'd0);
        ARESET = 1'b0;

        // Quarter-cycle step, with a latency check
        phase_inc = 32'h4000_0000;
        push_quarter(24);
        enable = 1'b1;
        n = 0;
        while (!m_axis_tvalid && n < 10) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        check("latency", n, 3);
        wait_accepted(16, 1'b0);

        // Offset only, zero increment
        apply_reset();
        phase_inc = 32'h0;
        phase_offset = 32'h4000_0000;
        for (int i = 0; i < 16; i++) expq.push_back(16'h7FFF);
        enable = 1'b1;
        wait_accepted(8, 1'b0);
        apply_reset();
        phase_offset = 32'h8000_0000;
        for (int i = 0; i < 16; i++) expq.push_back(16'hFFE7);
        enable = 1'b1;
        wait_accepted(8, 1'b0);

        // Wrap-around with an all-ones increment
        apply_reset();
        phase_offset = 32'h0;
        phase_inc = 32'hFFFF_FFFF;
        for (int i = 0; i < 1032; i++) expq.push_back(model(32'(i) * 32'hFFFF_FFFF));
        enable = 1'b1;
        wait_accepted(1024, 1'b0);

        // Random backpressure
        apply_reset();
        phase_inc = 32'h4000_0000;
        push_quarter(48);
        enable = 1'b1;
        wait_accepted(40, 1'b1);

        // Clear mid-stream, asserted together with enable
        apply_reset();
        phase_inc = 32'h4000_0000;
        for (int i = 0; i < 7; i++) expq.push_back(QT[i % 4]);
        push_quarter(24);
        enable = 1'b1;
        repeat (6) @(posedge ACLK);
        #1;
        acc_clr = 1'b1;
        @(posedge ACLK);
        #1;
        acc_clr = 1'b0;
        wait_accepted(24, 1'b0);

        // Asynchronous reset during a stall
        apply_reset();
        phase_inc = 32'h4000_0000;
        m_axis_tready = 1'b0;
        push_quarter(8);
        enable = 1'b1;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        check("stall_pre_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("stall_pre_data", {16'b0, m_axis_tdata}, 32'h0019);
        @(negedge ACLK);
        #2;
        ARESET = 1'b1;
        #1;
        check("async_rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("async_rst_tdata", {16'b0, m_axis_tdata}, 32'd0);
        expq.delete();
        popped = 0;
        repeat (2) @(posedge ACLK);
        #1;
        m_axis_tready = 1'b1;
        push_quarter(16);
        ARESET = 1'b0;
        wait_accepted(8, 1'b0);

        apply_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
